// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory boot loader: FSM encoding and stream/word widths.
package imem_loader_pkg;

    localparam int BYTE_W  = 8;
    localparam int INSTR_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Big-endian byte-to-word packer: first byte lands in [31:24].
// word_vld pulses the cycle after the 4th byte; never stalls, accepts a byte every cycle.
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               byte_vld,
    input  logic [BYTE_W-1:0]  byte_dat,
    output logic               word_last,
    output logic               word_vld,
    output logic [INSTR_W-1:0] word_dat
);

    logic [INSTR_W-1:0] shreg_q, shreg_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               word_vld_q, word_vld_d;

    always_comb begin
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        word_vld_d = 1'b0;
        word_last  = byte_vld && !clear && (cnt_q == 2'd3);
        if (clear) begin
            cnt_d = '0;
        end else if (byte_vld) begin
            shreg_d    = {shreg_q[INSTR_W-BYTE_W-1:0], byte_dat};
            cnt_d      = cnt_q + 2'd1;
            word_vld_d = word_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q    <= '0;
            cnt_q      <= '0;
            word_vld_q <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            word_vld_q <= word_vld_d;
        end
    end

    assign word_vld = word_vld_q;
    assign word_dat = shreg_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: 16-bit length header, then N big-endian words written to instruction RAM.
// Optional trailing XOR checksum byte under IMEM_LOADER_CHECKSUM_EN; 1 byte/cycle throughput.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [BYTE_W-1:0]  Rx_Data,
    input  logic               Rx_Valid,
    output logic               Rx_Ready,
    output logic               Mem_WrEn,
    output logic [31:0]        Mem_Addr,
    output logic [INSTR_W-1:0] Mem_WrData,
    output logic               Busy,
    output logic               Done,
    output logic               Error,
    output logic [ADDR_W:0]    Word_Count
);

    state_t            state_q, state_d, fin_state;
    logic [BYTE_W-1:0] len_hi_q, len_hi_d;
    logic              len_byte_q, len_byte_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic [31:0]       addr_q, addr_d;
    logic              acc, clear, word_last, last_written, oversize;
    logic [15:0]       n_full;

    // Last word is in its write cycle: hold off the stream until the FSM moves on.
    assign last_written = (word_count_q == len_q);
    assign Rx_Ready     = (state_q == ST_LEN) || (state_q == ST_CSUM) ||
                          ((state_q == ST_DATA) && !last_written);
    assign acc          = Rx_Valid && Rx_Ready;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_d;

    assign fin_state = ST_CSUM;

    always_comb begin
        csum_d = csum_q;
        if (clear) begin
            csum_d = '0;
        end else if (acc && ((state_q == ST_LEN) || (state_q == ST_DATA))) begin
            csum_d = csum_q ^ Rx_Data;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) csum_q <= '0;
        else        csum_q <= csum_d;
    end
`else
    assign fin_state = ST_DONE;
`endif

    always_comb begin
        state_d      = state_q;
        len_hi_d     = len_hi_q;
        len_byte_d   = len_byte_q;
        len_d        = len_q;
        word_count_d = word_count_q;
        addr_d       = addr_q;
        clear        = 1'b0;
        n_full       = {len_hi_q, Rx_Data};
        oversize     = 32'(n_full) > (32'd1 << ADDR_W);
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (Start) begin
                    state_d      = ST_LEN;
                    clear        = 1'b1;
                    len_byte_d   = 1'b0;
                    word_count_d = '0;
                    addr_d       = BASE_ADDR;
                end
            end
            ST_LEN: begin
                if (acc) begin
                    len_byte_d = 1'b1;
                    len_hi_d   = Rx_Data;
                    if (len_byte_q) begin
                        len_d = (ADDR_W+1)'(n_full);
                        if (oversize)           state_d = ST_ERR;
                        else if (n_full == '0)  state_d = fin_state;
                        else                    state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (last_written) state_d = fin_state;
                if (word_last) begin
                    word_count_d = word_count_q + (ADDR_W+1)'(1);
                    addr_d       = BASE_ADDR + (32'(word_count_q) << 2);
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (acc) state_d = (Rx_Data == csum_q) ? ST_DONE : ST_ERR;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            len_hi_q     <= '0;
            len_byte_q   <= 1'b0;
            len_q        <= '0;
            word_count_q <= '0;
            addr_q       <= BASE_ADDR;
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            len_byte_q   <= len_byte_d;
            len_q        <= len_d;
            word_count_q <= word_count_d;
            addr_q       <= addr_d;
        end
    end

    imem_word_assembler u_asm (
        .clk       (Clk),
        .rst_n     (Reset),
        .clear     (clear),
        .byte_vld  (acc && (state_q == ST_DATA)),
        .byte_dat  (Rx_Data),
        .word_last (word_last),
        .word_vld  (Mem_WrEn),
        .word_dat  (Mem_WrData)
    );

    assign Mem_Addr   = addr_q;
    assign Busy       = is_busy(state_q);
    assign Done       = (state_q == ST_DONE);
    assign Error      = (state_q == ST_ERR);
    assign Word_Count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a stream-level model predicts every RAM write and the final status.
module tb_imem_loader;

    localparam int          ADDR_W = 10;
    localparam logic [31:0] BASE   = 32'h0000_0000;

    logic              Clk = 1'b0;
    logic              Reset, Start, Rx_Valid, Rx_Ready, Mem_WrEn, Busy, Done, Error;
    logic [7:0]        Rx_Data;
    logic [31:0]       Mem_Addr, Mem_WrData;
    logic [ADDR_W:0]   Word_Count;

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Rx_Data(Rx_Data), .Rx_Valid(Rx_Valid),
        .Rx_Ready(Rx_Ready), .Mem_WrEn(Mem_WrEn), .Mem_Addr(Mem_Addr), .Mem_WrData(Mem_WrData),
        .Busy(Busy), .Done(Done), .Error(Error), .Word_Count(Word_Count)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] s[$], input int upto);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < upto; i++) x ^= s[i];
        return x;
    endfunction

    // Stream-level model: parse header, slice words, judge the trailer.
    task automatic model(input logic [7:0] s[$], output logic e_done, output logic e_err,
                         output int e_cnt);
        int n;
        n      = {s[0], s[1]};
        e_done = 1'b0;
        e_err  = 1'b0;
        e_cnt  = 0;
        if (n > (1 << ADDR_W)) begin
            e_err = 1'b1;
        end else begin
            for (int k = 0; k < n; k++) begin
                exp_addr_q.push_back(BASE + 32'(4 * k));
                exp_data_q.push_back({s[2+4*k], s[3+4*k], s[4+4*k], s[5+4*k]});
            end
            e_cnt = n;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (s[2+4*n] == xsum(s, 2 + 4 * n)) e_done = 1'b1;
            else                                e_err  = 1'b1;
`else
            e_done = 1'b1;
`endif
        end
    endtask

    always @(negedge Clk) begin
        if (Reset) begin
            check("busy_done_excl", {31'd0, Busy & Done}, 32'd0);
            if (Mem_WrEn) begin
                check("write_expected", {31'd0, exp_addr_q.size() > 0}, 32'd1);
                check("wr_addr_aligned", {30'd0, Mem_Addr[1:0]}, 32'd0);
                if (exp_addr_q.size() > 0) begin
                    check("wr_addr", Mem_Addr, exp_addr_q.pop_front());
                    check("wr_data", Mem_WrData, exp_data_q.pop_front());
                end
            end
        end
    end

    task automatic run_stream(input logic [7:0] s[$], input bit toggle, output int cycles);
        int idx = 0;
        bit ph  = 1'b0;
        bit accepted;
        cycles = 0;
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        while (idx < s.size() && cycles < 400) begin
            Rx_Valid = toggle ? ~ph : 1'b1;
            Rx_Data  = s[idx];
            ph       = ~ph;
            accepted = Rx_Valid && Rx_Ready;
            @(posedge Clk);
            cycles++;
            if (accepted) idx++;
            @(negedge Clk);
        end
        Rx_Valid = 1'b0;
        Rx_Data  = 8'h00;
        check("stream_accepted", idx, s.size());
    endtask

    task automatic finish_check(input string tag, input logic e_done, input logic e_err,
                                input int e_cnt);
        int t = 0;
        while (!(Done || Error) && t < 50) begin
            @(negedge Clk);
            t++;
        end
        repeat (3) @(negedge Clk);
        check({tag, "_done"}, {31'd0, Done}, {31'd0, e_done});
        check({tag, "_error"}, {31'd0, Error}, {31'd0, e_err});
        check({tag, "_count"}, 32'(Word_Count), e_cnt);
        check({tag, "_rdy"}, {31'd0, Rx_Ready}, 32'd0);
        check({tag, "_busy"}, {31'd0, Busy}, 32'd0);
        check({tag, "_writes_left"}, exp_addr_q.size(), 32'd0);
    endtask

    task automatic add_trailer(inout logic [7:0] s[$]);
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(xsum(s, s.size()));
`endif
    endtask

    initial begin
        logic [7:0] s1[$];
        logic [7:0] s[$];
        logic e_done, e_err;
        int e_cnt, cyc;

        Reset = 1'b0; Start = 1'b0; Rx_Valid = 1'b0; Rx_Data = 8'h00;
        repeat (3) @(negedge Clk);
        check("rst_rdy", {31'd0, Rx_Ready}, 32'd0);
        check("rst_wren", {31'd0, Mem_WrEn}, 32'd0);
        check("rst_addr", Mem_Addr, BASE);
        check("rst_status", {29'd0, Busy, Done, Error}, 32'd0);
        check("rst_count", 32'(Word_Count), 32'd0);
        Reset = 1'b1;
        @(negedge Clk);

        // Two words, valid held high
        s1 = '{8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h22, 8'h00, 8'h0C};
        add_trailer(s1);
        model(s1, e_done, e_err, e_cnt);
        check("model_nwords", exp_addr_q.size(), 32'd2);
        check("model_w0_data", exp_data_q[0], 32'h2401_0005);
        check("model_w1_addr", exp_addr_q[1], 32'h0000_0004);
        check("model_w1_data", exp_data_q[1], 32'h8C22_000C);
        run_stream(s1, 1'b0, cyc);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("t1_cycles", cyc, 32'd12);
`else
        check("t1_cycles", cyc, 32'd10);
`endif
        finish_check("t1", e_done, e_err, e_cnt);
        check("t1_last_addr", Mem_Addr, 32'h0000_0004);

        // Same stream, valid toggling every cycle
        model(s1, e_done, e_err, e_cnt);
        run_stream(s1, 1'b1, cyc);
        finish_check("t2", e_done, e_err, e_cnt);

        // Empty program
        s = '{8'h00, 8'h00};
        add_trailer(s);
        model(s, e_done, e_err, e_cnt);
        run_stream(s, 1'b0, cyc);
        finish_check("t3", e_done, e_err, e_cnt);
        check("t3_count_lit", 32'(Word_Count), 32'd0);

        // Oversized length 1025
        s = '{8'h04, 8'h01};
        model(s, e_done, e_err, e_cnt);
        check("model_oversize", {31'd0, e_err}, 32'd1);
        run_stream(s, 1'b0, cyc);
        finish_check("t4", e_done, e_err, e_cnt);

        // Reset after two data bytes of word 0, then restart with the full stream
        s = '{8'h00, 8'h02, 8'h24, 8'h01};
        run_stream(s, 1'b0, cyc);
        Reset = 1'b0;
        #1;
        check("t5_rst_wren", {31'd0, Mem_WrEn}, 32'd0);
        check("t5_rst_busy", {31'd0, Busy}, 32'd0);
        check("t5_rst_addr", Mem_Addr, BASE);
        @(negedge Clk);
        Reset = 1'b1;
        model(s1, e_done, e_err, e_cnt);
        run_stream(s1, 1'b0, cyc);
        finish_check("t5", e_done, e_err, e_cnt);

`ifdef IMEM_LOADER_CHECKSUM_EN
        s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        check("model_xsum", {24'd0, xsum(s, 6)}, 32'h0000_0009);
        s.push_back(xsum(s, 6));
        model(s, e_done, e_err, e_cnt);
        run_stream(s, 1'b0, cyc);
        finish_check("t6", e_done, e_err, e_cnt);
        s[6] = s[6] ^ 8'h01;
        model(s, e_done, e_err, e_cnt);
        check("model_csum_bad", {31'd0, e_err}, 32'd1);
        run_stream(s, 1'b0, cyc);
        finish_check("t7", e_done, e_err, e_cnt);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
